// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// i2c_pkg : shared states, op encodings and op-list helpers for i2c_seq_ctrl
// Revision: 1.0
// ============================================================================
package i2c_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_OPEN      = 3'd1,
    S_WAIT_RDY  = 3'd2,
    S_TRIG      = 3'd3,
    S_WAIT_BUSY = 3'd4,
    S_STOP_WAIT = 3'd5,
    S_RESP      = 3'd6
  } state_e;

  // Op codes are the {m_start, m_stop} pair presented with m_trig
  typedef logic [1:0] op_t;
  localparam op_t c_OP_WR     = 2'b00;
  localparam op_t c_OP_STOP   = 2'b01;
  localparam op_t c_OP_RSTART = 2'b10;
  localparam op_t c_OP_RD     = 2'b11;

  localparam int c_WR_OPS = 4;
  localparam int c_RD_OPS = 6;
  localparam int c_IDX_W  = 3;

  typedef struct packed {
    logic       rw;
    logic [6:0] dev;
    logic [7:0] reg_addr;
    logic [7:0] wdata;
  } req_t;

  function automatic op_t op_at(input logic rw, input logic [c_IDX_W-1:0] idx);
    op_t op;
    op = c_OP_WR;
    if (!rw) begin
      if (idx == c_IDX_W'(c_WR_OPS - 1)) op = c_OP_STOP;
    end else begin
      case (idx)
        3'd2:    op = c_OP_RSTART;
        3'd4:    op = c_OP_RD;
        3'd5:    op = c_OP_STOP;
        default: op = c_OP_WR;
      endcase
    end
    return op;
  endfunction

  function automatic logic [7:0] tx_byte(input req_t r, input logic [c_IDX_W-1:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      3'd0:    b = {r.dev, 1'b0};
      3'd1:    b = r.reg_addr;
      3'd2:    b = r.rw ? 8'h00 : r.wdata;
      3'd3:    b = r.rw ? {r.dev, 1'b1} : 8'h00;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// i2c_seq_ctrl_if : request/response handshake plus I2C master control bundle
// Revision: 1.0
// ============================================================================
interface i2c_seq_ctrl_if;

  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [6:0] req_dev_addr;
  logic [7:0] req_reg_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_nack;
  logic       rsp_err;
  logic       m_en;
  logic       m_trig;
  logic       m_start;
  logic       m_stop;
  logic       m_ack;
  logic [7:0] m_tx_data;
  logic       m_tx_ready;
  logic       m_tx_done;
  logic       m_rx_done;
  logic [7:0] m_rx_data;

  // Environment side: issues requests and plays the I2C master
  modport master (
    output req_valid, req_rw, req_dev_addr, req_reg_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_err,
    input  m_en, m_trig, m_start, m_stop, m_ack, m_tx_data,
    output m_tx_ready, m_tx_done, m_rx_done, m_rx_data
  );

  // Sequencer side
  modport slave (
    input  req_valid, req_rw, req_dev_addr, req_reg_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_err,
    output m_en, m_trig, m_start, m_stop, m_ack, m_tx_data,
    input  m_tx_ready, m_tx_done, m_rx_done, m_rx_data
  );

endinterface
`default_nettype wire

// File: rtl/i2c_seq_timer.sv
`default_nettype none
// ============================================================================
// i2c_seq_timer : loadable saturating down-counter with expire flag
// Revision: 1.0
// ============================================================================
module i2c_seq_timer #(
  parameter int WIDTH = 16
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             load_i,
  input  wire logic [WIDTH-1:0] load_val_i,
  input  wire logic             en_i,
  output logic                  expired_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/i2c_seq_ctrl.sv
`default_nettype none
// ============================================================================
// i2c_seq_ctrl : sequences one register write/read as an op list on an I2C master
// Revision: 1.0
// ============================================================================
module i2c_seq_ctrl
  import i2c_pkg::*;
#(
  parameter int TIMEOUT_CYC = 65535,
  parameter int STOP_CYC    = 1000
) (
  input  wire logic     clk,
  input  wire logic     reset,
  i2c_seq_ctrl_if.slave bus
);

  localparam int c_MAX_CYC = (TIMEOUT_CYC > STOP_CYC) ? TIMEOUT_CYC : STOP_CYC;
  localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);

  state_e               state_q, state_d;
  req_t                 req_q;
  logic [c_IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]           rdata_q, rdata_d;
  logic                 nack_q, nack_d;
  logic                 err_q, err_d;

  op_t                  w_op;
  logic                 w_last_rd;
  logic                 w_accept;
  logic                 w_tmr_load;
  logic                 w_tmr_en;
  logic                 w_tmr_exp;
  logic [c_CNT_W-1:0]   w_tmr_val;
  logic                 w_unused;

  assign w_op      = op_at(req_q.rw, idx_q);
  // Index of the STOP that follows RD: first ready here means the read byte is in
  assign w_last_rd = req_q.rw && (idx_q == c_IDX_W'(c_RD_OPS - 1));
  assign w_accept  = (state_q == S_IDLE) && bus.req_valid;
  assign w_unused  = bus.m_tx_done;

  // Timer restarts on every state change; the load value depends on where we land
  assign w_tmr_load = (state_d != state_q);
  assign w_tmr_val  = (state_d == S_STOP_WAIT) ? c_CNT_W'(STOP_CYC - 1)
                                               : c_CNT_W'(TIMEOUT_CYC - 1);
  assign w_tmr_en   = (state_q == S_WAIT_RDY) || (state_q == S_WAIT_BUSY) ||
                      (state_q == S_STOP_WAIT);

  i2c_seq_timer #(
    .WIDTH (c_CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (w_tmr_load),
    .load_val_i (w_tmr_val),
    .en_i       (w_tmr_en),
    .expired_o  (w_tmr_exp)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      idx_q   <= '0;
      rdata_q <= '0;
      nack_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      nack_q  <= nack_d;
      err_q   <= err_d;
      if (w_accept) begin
        req_q <= '{rw:       bus.req_rw,
                   dev:      bus.req_dev_addr,
                   reg_addr: bus.req_reg_addr,
                   wdata:    bus.req_wdata};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
    nack_d  = nack_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          state_d = S_OPEN;
          idx_d   = '0;
          rdata_d = '0;
          nack_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_OPEN: state_d = S_WAIT_RDY;
      S_WAIT_RDY: begin
        // NACK outranks both progress and timeout in the same cycle
        if (bus.m_rx_done) begin
          nack_d  = 1'b1;
          state_d = S_STOP_WAIT;
        end else if (bus.m_tx_ready) begin
          state_d = S_TRIG;
          if (w_last_rd) rdata_d = bus.m_rx_data;
        end else if (w_tmr_exp) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_TRIG: state_d = (w_op == c_OP_STOP) ? S_STOP_WAIT : S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (bus.m_rx_done) begin
          nack_d  = 1'b1;
          state_d = S_STOP_WAIT;
        end else if (!bus.m_tx_ready) begin
          idx_d   = idx_q + c_IDX_W'(1);
          state_d = S_WAIT_RDY;
        end else if (w_tmr_exp) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_STOP_WAIT: if (w_tmr_exp) state_d = S_RESP;
      S_RESP:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state_q == S_IDLE);
    bus.rsp_valid = (state_q == S_RESP);
    bus.rsp_rdata = rdata_q;
    bus.rsp_nack  = nack_q;
    bus.rsp_err   = err_q;
    bus.m_en      = (state_q == S_OPEN);
    bus.m_trig    = (state_q == S_TRIG);
    bus.m_start   = (state_q == S_TRIG) && w_op[1];
    bus.m_stop    = (state_q == S_TRIG) && w_op[0];
    bus.m_ack     = 1'b0;
    bus.m_tx_data = (state_q == S_TRIG) ? tx_byte(req_q, idx_q) : 8'h00;
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_i2c_seq_ctrl : directed bench with a behavioural I2C master model
// Revision: 1.0
// ============================================================================
module tb_i2c_seq_ctrl;

  localparam int TIMEOUT_CYC = 100;
  localparam int STOP_CYC    = 8;
  localparam int BUSY_CYC    = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  i2c_seq_ctrl_if bus ();

  i2c_seq_ctrl #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .STOP_CYC    (STOP_CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Master model state and bench-side monitors
  int         cyc = 0;
  int         busy_cnt = 0;
  int         trig_cnt = 0;
  int         last_trig_cyc = 0;
  int         rxd_cyc = 0;
  int         viol = 0;
  logic       prev_rdy = 1'b0;
  logic       stuck_mode = 1'b0;
  logic       nack_mode = 1'b0;
  int         nack_at = 0;
  logic [9:0] trig_log[$];
  int         acc_q[$];
  int         rsp_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    prev_rdy <= bus.m_tx_ready;
    if (bus.m_trig && !prev_rdy) viol <= viol + 1;
    if (!reset && bus.req_valid && bus.req_ready) acc_q.push_back(cyc);
    if (!reset && bus.rsp_valid) rsp_q.push_back(cyc);
    if (reset) begin
      bus.m_tx_ready <= !stuck_mode;
      bus.m_rx_done  <= 1'b0;
      bus.m_tx_done  <= 1'b0;
      busy_cnt       <= 0;
      trig_cnt       <= 0;
    end else begin
      bus.m_rx_done <= 1'b0;
      bus.m_tx_done <= 1'b0;
      if (bus.m_trig) begin
        trig_log.push_back({bus.m_start, bus.m_stop, bus.m_tx_data});
        trig_cnt       <= trig_cnt + 1;
        last_trig_cyc  <= cyc;
        bus.m_tx_ready <= 1'b0;
        busy_cnt       <= BUSY_CYC;
      end else if (busy_cnt == 1) begin
        busy_cnt <= 0;
        if (nack_mode && trig_cnt == nack_at) begin
          bus.m_rx_done <= 1'b1;
          rxd_cyc       <= cyc + 1;
        end else begin
          bus.m_tx_ready <= 1'b1;
          bus.m_tx_done  <= 1'b1;
        end
      end else if (busy_cnt > 1) begin
        busy_cnt <= busy_cnt - 1;
      end
    end
  end

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    trig_log.delete();
    acc_q.delete();
    rsp_q.delete();
  endtask

  // Request is taken on the first edge since the DUT is idle; fields are then scrambled
  task automatic do_req(input logic rw, input logic [6:0] dev, input logic [7:0] ra,
                        input logic [7:0] wd);
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_rw       = rw;
    bus.req_dev_addr = dev;
    bus.req_reg_addr = ra;
    bus.req_wdata    = wd;
    @(negedge clk);
    bus.req_valid    = 1'b0;
    bus.req_rw       = ~rw;
    bus.req_dev_addr = 7'h7F;
    bus.req_reg_addr = 8'hFF;
    bus.req_wdata    = 8'h5A;
  endtask

  task automatic wait_rsp(input string tag, output logic [9:0] rsp);
    logic seen;
    seen = 1'b0;
    rsp  = '0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        seen = 1'b1;
        rsp  = {bus.rsp_nack, bus.rsp_err, bus.rsp_rdata};
      end
    end
    check_eq({tag, "_rsp_seen"}, {31'd0, seen}, 32'd1);
  endtask

  logic [9:0] exp_wr[4] = '{10'h0A0, 10'h010, 10'h0A5, 10'h100};
  logic [9:0] exp_rd[6] = '{10'h0A0, 10'h020, 10'h200, 10'h0A1, 10'h300, 10'h100};

  initial begin
    logic [9:0] rsp;
    int         n_pulse;
    int         n_before;
    logic       hit;

    bus.req_valid    = 1'b0;
    bus.req_rw       = 1'b0;
    bus.req_dev_addr = '0;
    bus.req_reg_addr = '0;
    bus.req_wdata    = '0;
    bus.m_rx_data    = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outputs",
             {bus.req_ready, bus.rsp_valid, bus.rsp_nack, bus.rsp_err, bus.m_en,
              bus.m_trig, bus.m_start, bus.m_stop, bus.m_ack, bus.m_tx_data, bus.rsp_rdata},
             {1'b1, 8'b0, 16'h0000});
    reset = 1'b0;
    trig_log.delete();

    // Register write
    do_req(1'b0, 7'h50, 8'h10, 8'hA5);
    wait_rsp("wr", rsp);
    check_eq("wr_nack_err_rdata", {22'd0, rsp}, 32'h000);
    @(negedge clk);
    check_eq("wr_op_count", trig_log.size(), 4);
    for (int i = 0; i < 4; i++) check_eq($sformatf("wr_op%0d", i), {22'd0, trig_log[i]}, {22'd0, exp_wr[i]});
    check_eq("wr_stop_latency", rsp_q[0] - last_trig_cyc, STOP_CYC + 1);

    // Register read
    reset_dut();
    bus.m_rx_data = 8'h3C;
    do_req(1'b1, 7'h50, 8'h20, 8'h00);
    wait_rsp("rd", rsp);
    check_eq("rd_nack_err_rdata", {22'd0, rsp}, 32'h03C);
    @(negedge clk);
    check_eq("rd_op_count", trig_log.size(), 6);
    for (int i = 0; i < 6; i++) check_eq($sformatf("rd_op%0d", i), {22'd0, trig_log[i]}, {22'd0, exp_rd[i]});
    check_eq("rd_rsp_hold", {22'd0, bus.rsp_nack, bus.rsp_err, bus.rsp_rdata}, 32'h03C);

    // Slave NACKs the address byte
    nack_mode = 1'b1;
    nack_at   = 1;
    reset_dut();
    do_req(1'b0, 7'h50, 8'h10, 8'hA5);
    wait_rsp("nack", rsp);
    check_eq("nack_nack_err_rdata", {22'd0, rsp}, 32'h200);
    @(negedge clk);
    check_eq("nack_trig_count", trig_log.size(), 1);
    check_eq("nack_stop_latency", rsp_q[0] - rxd_cyc, STOP_CYC + 1);
    nack_mode = 1'b0;

    // Master never becomes ready
    stuck_mode = 1'b1;
    reset_dut();
    do_req(1'b0, 7'h50, 8'h10, 8'hA5);
    wait_rsp("tmo", rsp);
    check_eq("tmo_nack_err_rdata", {22'd0, rsp}, 32'h100);
    @(negedge clk);
    check_eq("tmo_latency", rsp_q[0] - acc_q[0], TIMEOUT_CYC + 2);
    check_eq("tmo_trig_count", trig_log.size(), 0);
    check_eq("tmo_req_ready", {31'd0, bus.req_ready}, 32'd1);
    stuck_mode = 1'b0;

    // Two back-to-back writes with req_valid held high
    reset_dut();
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_rw       = 1'b0;
    bus.req_dev_addr = 7'h50;
    bus.req_reg_addr = 8'h11;
    bus.req_wdata    = 8'h22;
    n_pulse = 0;
    for (int i = 0; i < 600 && n_pulse < 2; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) n_pulse++;
    end
    bus.req_valid = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("b2b_rsp_count", rsp_q.size(), 2);
    check_eq("b2b_acc_count", acc_q.size(), 2);
    check_eq("b2b_second_accept_gap", acc_q[1] - rsp_q[0], 1);
    check_eq("b2b_trig_count", trig_log.size(), 8);

    // Reset while the RD op is in flight
    reset_dut();
    bus.m_rx_data = 8'h77;
    do_req(1'b1, 7'h50, 8'h20, 8'h00);
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      if (bus.m_trig && bus.m_start && bus.m_stop) hit = 1'b1;
    end
    check_eq("rst_rd_trig_seen", {31'd0, hit}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_ready_no_rsp", {30'd0, bus.req_ready, bus.rsp_valid}, 32'h2);
    reset = 1'b0;
    n_before = rsp_q.size();
    repeat (30) @(negedge clk);
    check_eq("rst_no_rsp_after", rsp_q.size(), n_before);

    check_eq("trig_without_ready", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/i2c_seq_ctrl.md
I2C_SEQ_CTRL -- requirements
Module: i2c_seq_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 65535: maximum clocks to wait for any master handshake before aborting.
REQ-002 SHALL have parameter STOP_CYC, default 1000: clocks allowed for the master's STOP condition to complete.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  system clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 req_valid  in  1  transaction request.
REQ-007 req_ready  out  1  controller idle; a request is accepted when both req_valid and req_ready are high.
REQ-008 req_rw  in  1  0 = register write, 1 = register read.
REQ-009 req_dev_addr  in  7  slave address.
REQ-010 req_reg_addr  in  8  register address.
REQ-011 req_wdata  in  8  write data.
REQ-012 rsp_valid  out  1  one-cycle completion pulse.
REQ-013 rsp_rdata  out  8  read data; 0 for writes and failed transactions.
REQ-014 rsp_nack  out  1  slave NACKed; valid with rsp_valid.
REQ-015 rsp_err  out  1  timeout abort; valid with rsp_valid.
REQ-016 m_en, m_trig, m_start, m_stop, m_ack  out  1 each  I2C master controls.
REQ-017 m_tx_data  out  8  byte to the master.
REQ-018 m_tx_ready, m_tx_done, m_rx_done  in  1 each  master status.
REQ-019 m_rx_data  in  8  master read byte.

Function
REQ-020 SHALL latch all req_* fields on acceptance; later changes to the req_* inputs SHALL be ignored until rsp_valid.
REQ-021 Op lists: write = [WR {dev,0}, WR reg, WR wdata, STOP]; read = [WR {dev,0}, WR reg, RSTART, WR {dev,1}, RD, STOP].
REQ-022 Op encoding {m_start,m_stop} with a one-cycle m_trig: WR = 00, STOP = 01, RSTART = 10, RD = 11; m_tx_data SHALL be valid in the m_trig cycle.
REQ-023 States: IDLE, OPEN, WAIT_RDY, TRIG, WAIT_BUSY, STOP_WAIT, RESP.
REQ-024 IDLE: req_ready = 1; on acceptance, go to OPEN with the op index cleared.
REQ-025 OPEN: m_en pulses for exactly one cycle, then go to WAIT_RDY.
REQ-026 WAIT_RDY: when m_tx_ready = 1, go to TRIG; if the op is STOP, go to TRIG and then to STOP_WAIT.
REQ-027 TRIG: m_trig = 1 for exactly one cycle, then go to WAIT_BUSY.
REQ-028 WAIT_BUSY: when m_tx_ready = 0, advance the op index and go to WAIT_RDY.
REQ-029 The controller SHALL never assert m_trig unless m_tx_ready was high in the preceding cycle.
REQ-030 RD completion: on the first m_tx_ready = 1 after RD, capture m_rx_data into rsp_rdata.
REQ-031 NACK: an m_rx_done pulse in WAIT_RDY or WAIT_BUSY SHALL set the nack flag and jump to STOP_WAIT, because the master issues STOP itself.
REQ-032 STOP_WAIT: count STOP_CYC clocks, then go to RESP.
REQ-033 RESP: rsp_valid = 1 for one cycle, then go to IDLE; back-to-back requests are accepted the following cycle.
REQ-034 Timeout counter: runs in WAIT_RDY and WAIT_BUSY, clears on every state change, and on reaching TIMEOUT_CYC sets rsp_err and goes to RESP.
REQ-035 rsp_nack and rsp_err SHALL be mutually exclusive; if both conditions occur in the same cycle, NACK wins.
REQ-036 m_ack SHALL be held 0 (NACK the single read byte).
REQ-037 rsp_* outputs SHALL hold their values until the next acceptance.

Reset
REQ-038 Reset SHALL force state IDLE and clear the op index and both counters.
REQ-039 On reset, all outputs SHALL be 0 except req_ready = 1.
REQ-040 Reset mid-transaction SHALL drop the transaction without rsp_valid; the master is reset on the same reset net.

Structure
REQ-041 The state enum, op encoding constants and op-list length constants SHALL live in the shared package i2c_pkg.
REQ-042 The op sequencing SHALL be flat in one module; a single sub-module, i2c_seq_timer (loadable down-counter with expire flag), SHALL serve both the timeout and STOP_CYC counts.

Verification
REQ-043 Write dev=0x50, reg=0x10, data=0xA5 to the real i2c_master plus an ACKing slave model -> SDA bytes A0,10,A5 then STOP; rsp_valid with nack=0, err=0, rdata=0x00.
REQ-044 Read dev=0x50, reg=0x20 with the slave returning 0x3C -> bytes A0,20, repeated START, A1, read; rsp_rdata=0x3C, nack=0.
REQ-045 Slave NACKs the address byte -> m_rx_done pulse, no further m_trig, rsp_nack=1 after STOP_CYC clocks, rdata=0.
REQ-046 Master model never raises m_tx_ready with TIMEOUT_CYC=100 -> rsp_err=1 exactly 100 clocks after OPEN+1; req_ready returns 1.
REQ-047 req_valid held high for two back-to-back writes -> two distinct rsp_valid pulses, with the second acceptance one cycle after the first RESP.
REQ-048 Reset asserted in WAIT_BUSY of the RD op -> next cycle IDLE with req_ready=1 and no rsp_valid.
